// File: rtl/sam_video_pkg.sv
// Shared video types for the SAM video path: pixel word layout, colour bit mapping
// and line-timing constants used by the video controller and the scandoubler.
package sam_video_pkg;

   localparam int unsigned SAMPLES_PER_LINE = 768;
   localparam int unsigned HS_LEN_DEF       = 64;
   localparam int unsigned MIN_LINE_DEF     = 16;
   localparam int unsigned LB_AW_DEF        = 10;

   typedef struct packed {
      logic       hblank;
      logic [6:0] colour;   // {G1,R1,B1,I,G0,R0,B0}
   } pix_word_t;

   typedef struct packed {
      logic [1:0] r;
      logic [1:0] g;
      logic [1:0] b;
      logic       i;
   } rgbi_t;

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_PASS0 = 2'd1,
      RD_PASS1 = 2'd2
   } rd_state_t;

   function automatic logic [6:0] pack_colour(input logic [1:0] r, input logic [1:0] g,
                                              input logic [1:0] b, input logic i);
      return {g[1], r[1], b[1], i, g[0], r[0], b[0]};
   endfunction

   function automatic rgbi_t unpack_colour(input logic [6:0] c);
      rgbi_t p;
      p.r = {c[5], c[1]};
      p.g = {c[6], c[2]};
      p.b = {c[4], c[0]};
      p.i = c[3];
      return p;
   endfunction

endpackage

// File: rtl/sam_linebuf.sv
// Ping-pong line buffer: two banks of 2^LB_AW pixel words, one write port and one
// registered read port; the bank select is the address MSB.
module sam_linebuf
   import sam_video_pkg::*;
#(
   parameter int unsigned LB_AW = LB_AW_DEF
)(
   input  logic             clk_sys,
   input  logic             we,
   input  logic             wr_bank,
   input  logic [LB_AW-1:0] wr_addr,
   input  pix_word_t        wr_data,
   input  logic             re,
   input  logic             rd_bank,
   input  logic [LB_AW-1:0] rd_addr,
   output pix_word_t        rd_data
);

   localparam int unsigned DEPTH = 2 ** (LB_AW + 1);

   pix_word_t mem [DEPTH];

   always_ff @(posedge clk_sys) begin
      if (we) mem[{wr_bank, wr_addr}] <= wr_data;
   end

   always_ff @(posedge clk_sys) begin
      if (re) rd_data <= mem[{rd_bank, rd_addr}];
   end

endmodule

// File: rtl/sam_scandoubler.sv
// Scandoubler: captures each 15.6 kHz input line at 12 MHz and replays it twice at
// 24 MHz for 31 kHz output; enable=0 passes the inputs through with one clock delay.
module sam_scandoubler
   import sam_video_pkg::*;
#(
   parameter int unsigned HS_LEN   = HS_LEN_DEF,
   parameter int unsigned MIN_LINE = MIN_LINE_DEF,
   parameter int unsigned LB_AW    = LB_AW_DEF
)(
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       ce_6mp,
   input  logic       ce_6mn,
   input  logic       ce_24m,
   input  logic       enable,
   input  logic [1:0] R_in,
   input  logic [1:0] G_in,
   input  logic [1:0] B_in,
   input  logic       I_in,
   input  logic       HSync_in,
   input  logic       VSync_in,
   input  logic       HBlank_in,
   input  logic       VBlank_in,
   output logic [1:0] R_out,
   output logic [1:0] G_out,
   output logic [1:0] B_out,
   output logic       I_out,
   output logic       HSync_out,
   output logic       VSync_out,
   output logic       HBlank_out,
   output logic       VBlank_out
);

   localparam logic [LB_AW-1:0] CNT_MAX = '1;

   logic             ce_in_c, line_start_c, accept_c, running_c, rd_last_c;
   logic             hs_prev, wr_bank, rd_bank;
   logic [LB_AW-1:0] wr_cnt, rd_cnt, rd_len, wr_addr_c;
   logic [1:0]       valid;
   logic             vs_pend, vb_pend, vs_cur, vb_cur;
   logic             s1_run, s1_hs, s1_vs, s1_vb, s1_dark;
   rd_state_t        rd_state, rd_state_nx;
   pix_word_t        wr_word_c, rd_word;
   rgbi_t            px_c;

   assign ce_in_c      = ce_6mp | ce_6mn;
   assign line_start_c = ce_in_c & HSync_in & ~hs_prev;
   assign accept_c     = line_start_c & (32'(wr_cnt) >= MIN_LINE);
   assign running_c    = (rd_state != RD_IDLE);
   assign rd_last_c    = (rd_cnt == rd_len - LB_AW'(1));
   assign wr_word_c    = '{hblank: HBlank_in, colour: pack_colour(R_in, G_in, B_in, I_in)};
   assign px_c         = unpack_colour(rd_word.colour);

   // The sample carrying the HSync edge is the first sample of the new line.
   assign wr_addr_c = line_start_c ? '0 : wr_cnt;

   sam_linebuf #(.LB_AW(LB_AW)) u_linebuf (
      .clk_sys (clk_sys),
      .we      (ce_in_c),
      .wr_bank (accept_c ? ~wr_bank : wr_bank),
      .wr_addr (wr_addr_c),
      .wr_data (wr_word_c),
      .re      (ce_24m & running_c),
      .rd_bank (rd_bank),
      .rd_addr (rd_cnt),
      .rd_data (rd_word)
   );

   // Capture side: edge detect, saturating write counter, bank flip on accepted lines.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         hs_prev <= 1'b0;
         wr_cnt  <= '0;
         wr_bank <= 1'b0;
      end else if (ce_in_c) begin
         hs_prev <= HSync_in;
         if (line_start_c)          wr_cnt <= LB_AW'(1);
         else if (wr_cnt != CNT_MAX) wr_cnt <= wr_cnt + LB_AW'(1);
         if (accept_c) wr_bank <= ~wr_bank;
      end
   end

   always_comb begin
      rd_state_nx = rd_state;
      if (accept_c) begin
         rd_state_nx = RD_PASS0;
      end else if (ce_24m && rd_last_c) begin
         case (rd_state)
            RD_PASS0: rd_state_nx = RD_PASS1;
            RD_PASS1: rd_state_nx = RD_IDLE;
            default:  rd_state_nx = rd_state;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) rd_state <= RD_IDLE;
      else       rd_state <= rd_state_nx;
   end

   // Replay bookkeeping; a new line start overrides any wrap or stall in progress.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         rd_bank <= 1'b0;
         rd_len  <= LB_AW'(SAMPLES_PER_LINE);
         rd_cnt  <= '0;
         valid   <= 2'd0;
         vs_pend <= 1'b0;
         vb_pend <= 1'b0;
         vs_cur  <= 1'b0;
         vb_cur  <= 1'b0;
      end else if (accept_c) begin
         rd_bank <= wr_bank;
         rd_len  <= wr_cnt;
         rd_cnt  <= '0;
         if (valid != 2'd2) valid <= valid + 2'd1;
         vs_cur  <= vs_pend;
         vb_cur  <= vb_pend;
         vs_pend <= VSync_in;
         vb_pend <= VBlank_in;
      end else if (ce_24m && running_c) begin
         rd_cnt <= rd_last_c ? '0 : rd_cnt + LB_AW'(1);
      end
   end

   // Issue-stage timing, aligned with the one-tick RAM read latency.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         s1_run  <= 1'b0;
         s1_hs   <= 1'b0;
         s1_vs   <= 1'b0;
         s1_vb   <= 1'b0;
         s1_dark <= 1'b1;
      end else if (ce_24m) begin
         s1_run  <= running_c;
         s1_hs   <= running_c & (32'(rd_cnt) < HS_LEN);
         s1_vs   <= vs_cur;
         s1_vb   <= vb_cur;
         s1_dark <= ~running_c | vb_cur | (valid != 2'd2);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         {R_out, G_out, B_out, I_out}                       <= '0;
         {HSync_out, VSync_out, HBlank_out, VBlank_out}     <= '0;
      end else if (!enable) begin
         {R_out, G_out, B_out, I_out}                       <= {R_in, G_in, B_in, I_in};
         {HSync_out, VSync_out, HBlank_out, VBlank_out}     <= {HSync_in, VSync_in, HBlank_in, VBlank_in};
      end else if (ce_24m) begin
         HSync_out  <= s1_hs;
         VSync_out  <= s1_vs;
         VBlank_out <= s1_vb;
         HBlank_out <= s1_run & rd_word.hblank;
         if (s1_dark | rd_word.hblank) begin
            {R_out, G_out, B_out, I_out} <= '0;
         end else begin
            {R_out, G_out, B_out, I_out} <= {px_c.r, px_c.g, px_c.b, px_c.i};
         end
      end
   end

endmodule

// File: tb/tb_sam_scandoubler.sv
// Randomized bench for sam_scandoubler against a line-level reference model that
// predicts each output tick from the captured line and the ticks since its line start.
module tb_sam_scandoubler;

   localparam int HS_LEN   = 64;
   localparam int MIN_LINE = 16;
   localparam int SAT      = 1023;

   logic       clk_sys = 1'b0;
   logic       reset, ce_6mp, ce_6mn, ce_24m, enable;
   logic [1:0] R_in, G_in, B_in, R_out, G_out, B_out;
   logic       I_in, HSync_in, VSync_in, HBlank_in, VBlank_in;
   logic       I_out, HSync_out, VSync_out, HBlank_out, VBlank_out;
   logic [10:0] act_c;

   always #5 clk_sys = ~clk_sys;

   sam_scandoubler dut (
      .clk_sys(clk_sys), .reset(reset), .ce_6mp(ce_6mp), .ce_6mn(ce_6mn), .ce_24m(ce_24m),
      .enable(enable), .R_in(R_in), .G_in(G_in), .B_in(B_in), .I_in(I_in),
      .HSync_in(HSync_in), .VSync_in(VSync_in), .HBlank_in(HBlank_in), .VBlank_in(VBlank_in),
      .R_out(R_out), .G_out(G_out), .B_out(B_out), .I_out(I_out),
      .HSync_out(HSync_out), .VSync_out(VSync_out), .HBlank_out(HBlank_out), .VBlank_out(VBlank_out)
   );

   assign act_c = {R_out, G_out, B_out, I_out, HSync_out, VSync_out, HBlank_out, VBlank_out};

   typedef struct packed {
      logic [1:0] r;
      logic [1:0] g;
      logic [1:0] b;
      logic       i;
      logic       hb;
   } samp_t;

   typedef struct packed {
      logic  run;
      logic  hs;
      logic  vs;
      logic  vb;
      logic  low_valid;
      samp_t w;
   } issue_t;

   int          n_chk = 0;
   int          n_bad = 0;
   int unsigned cyc   = 0;

   // Reference model state
   samp_t       cur_line[$];
   samp_t       play_line[$];
   int          play_len;
   int          k_tick;
   int          nvalid;
   logic        hs_prev_m, vs_pend_m, vb_pend_m, vs_play_m, vb_play_m;
   issue_t      last_issue;
   logic [10:0] exp_out;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h @%0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [10:0] issue_to_out(input issue_t p);
      logic dark;
      dark = !p.run || p.vb || p.low_valid || p.w.hb;
      if (dark) return {7'd0, p.run & p.hs, p.vs, p.run & p.w.hb, p.vb};
      return {p.w.r, p.w.g, p.w.b, p.w.i, p.hs, p.vs, 1'b0, p.vb};
   endfunction

   task automatic model_step();
      issue_t n;
      samp_t  s;
      int     idx;
      if (reset) begin
         cur_line.delete();
         play_line.delete();
         play_len  = 0;
         k_tick    = -1;
         nvalid    = 0;
         hs_prev_m = 1'b0;
         vs_pend_m = 1'b0;
         vb_pend_m = 1'b0;
         vs_play_m = 1'b0;
         vb_play_m = 1'b0;
         last_issue = '0;
         exp_out    = '0;
         return;
      end
      if (!enable)
         exp_out = {R_in, G_in, B_in, I_in, HSync_in, VSync_in, HBlank_in, VBlank_in};
      else if (ce_24m)
         exp_out = issue_to_out(last_issue);
      if (ce_24m) begin
         n = '0;
         n.vs = vs_play_m;
         n.vb = vb_play_m;
         n.low_valid = (nvalid < 2);
         if (k_tick >= 0 && k_tick < 2 * play_len) begin
            idx   = k_tick % play_len;
            n.run = 1'b1;
            n.w   = play_line[idx];
            n.hs  = (idx < HS_LEN);
         end
         if (k_tick >= 0) k_tick++;
         last_issue = n;
      end
      if (ce_6mp || ce_6mn) begin
         s.r = R_in; s.g = G_in; s.b = B_in; s.i = I_in; s.hb = HBlank_in;
         if (HSync_in && !hs_prev_m) begin
            if (cur_line.size() >= MIN_LINE) begin
               play_line = cur_line;
               play_len  = (cur_line.size() > SAT) ? SAT : cur_line.size();
               vs_play_m = vs_pend_m;
               vb_play_m = vb_pend_m;
               vs_pend_m = VSync_in;
               vb_pend_m = VBlank_in;
               k_tick    = 0;
               if (nvalid < 2) nvalid++;
            end
            cur_line.delete();
            cur_line.push_back(s);
         end else if (cur_line.size() <= SAT) begin
            cur_line.push_back(s);
         end else begin
            cur_line[SAT] = s;
         end
         hs_prev_m = HSync_in;
      end
   endtask

   task automatic run_cycle();
      ce_6mp = (cyc % 8 == 0);
      ce_6mn = (cyc % 8 == 4);
      ce_24m = cyc[0];
      @(posedge clk_sys);
      model_step();
      #1;
      check_eq("out", 32'(act_c), 32'(exp_out));
      @(negedge clk_sys);
      cyc++;
   endtask

   // One input line: n samples, HSync high for the first hsw, HBlank from hb_start on.
   task automatic send_line(input int n, input int hsw, input int hb_start,
                            input logic vs, input logic vb, input bit ramp);
      logic [6:0] c;
      for (int s = 0; s < n; s++) begin
         c = ramp ? 7'(s) : 7'($urandom);
         R_in = c[1:0]; G_in = c[3:2]; B_in = c[5:4]; I_in = c[6];
         HSync_in  = (s < hsw);
         HBlank_in = (s >= hb_start);
         VSync_in  = vs;
         VBlank_in = vb;
         repeat (4) run_cycle();
      end
   endtask

   task automatic pulse_reset(input int n);
      reset = 1'b1;
      repeat (n) run_cycle();
      check_eq("rst_out", 32'(act_c), 32'd0);
      reset = 1'b0;
   endtask

   initial begin
      int n, hb;
      reset = 1'b1; enable = 1'b1;
      ce_6mp = 1'b0; ce_6mn = 1'b0; ce_24m = 1'b0;
      {R_in, G_in, B_in, I_in, HSync_in, VSync_in, HBlank_in, VBlank_in} = '0;
      repeat (8) run_cycle();
      check_eq("reset", 32'(act_c), 32'd0);
      reset = 1'b0;

      // nominal ramp lines
      repeat (3) send_line(768, 64, 768, 1'b0, 1'b0, 1'b1);

      // random short lines with trailing HBlank
      repeat (10) begin
         n  = int'($urandom_range(20, 300));
         hb = n - int'($urandom_range(0, n / 4));
         send_line(n, int'($urandom_range(1, 8)), hb, 1'b0, 1'b0, 1'b0);
      end

      // glitch edge 5 samples after a line start
      send_line(400, 16, 380, 1'b0, 1'b0, 1'b0);
      send_line(5, 2, 5, 1'b0, 1'b0, 1'b0);
      send_line(395, 4, 395, 1'b0, 1'b0, 1'b0);
      send_line(768, 64, 768, 1'b0, 1'b0, 1'b1);

      // short lines then stall
      send_line(600, 64, 600, 1'b0, 1'b0, 1'b1);
      send_line(600, 64, 600, 1'b0, 1'b0, 1'b0);
      send_line(768, 64, 768, 1'b0, 1'b0, 1'b1);

      // over-long line saturates the write counter
      send_line(1100, 64, 1100, 1'b0, 1'b0, 1'b1);
      send_line(768, 64, 768, 1'b0, 1'b0, 1'b0);
      send_line(768, 64, 768, 1'b0, 1'b0, 1'b1);

      // vertical sync and blanking lines
      for (int l = 0; l < 10; l++)
         send_line(120, 8, 100, (l >= 3 && l < 7), (l >= 2 && l < 8), 1'b0);

      // bypass with inputs changing every clock
      enable = 1'b0;
      for (int c = 0; c < 400; c++) begin
         {R_in, G_in, B_in, I_in} = 7'($urandom);
         {HSync_in, VSync_in, HBlank_in, VBlank_in} = 4'($urandom);
         run_cycle();
      end
      enable = 1'b1;
      HSync_in = 1'b0;
      repeat (3) send_line(200, 8, 180, 1'b0, 1'b0, 1'b0);

      // reset in the middle of a replay pass
      send_line(300, 8, 300, 1'b0, 1'b0, 1'b1);
      pulse_reset(8);
      repeat (4) send_line(int'($urandom_range(40, 200)), 6, 1000, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
